// File: rtl/step_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : step_seq_pkg
// Purpose  : Shared types for the stepper move sequencer: FSM state encoding,
//            queued command record, default widths and the divider helper.
// Config   : STEP_SEQ_DWELL_EN adds a 16-bit dwell field to each command.
// Revision : 1.0 - initial release
// ============================================================================
package step_seq_pkg;

  localparam int C_DIV_W     = 32;
  localparam int C_CNT_W     = 31;
  localparam int C_DIR_SETUP = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_SETUP = 3'd2,
    ST_RUN   = 3'd3,
    ST_DWELL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // One queued move. Field widths are the widest supported configuration.
  typedef struct packed {
    logic [C_DIV_W-1:0] div;
    logic [C_CNT_W-1:0] steps;
    logic               dir;
`ifdef STEP_SEQ_DWELL_EN
    logic [15:0]        dwell;
`endif
  } cmd_t;

  // Phase length minus one; a divider of 0 behaves like 1.
  function automatic logic [C_DIV_W-1:0] f_div_m1(input logic [C_DIV_W-1:0] div);
    return (div == '0) ? '0 : div - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Purpose  : Emits a train of i_steps pulses, each (div) cycles high then
//            (div) cycles low. o_last is high during the final cycle of the
//            final low phase so the sequencer can leave RUN on time.
// Ports    : clk, reset (async, active-high)
//            i_clear  - drop the current train, step low next cycle
//            i_start  - load i_div_m1 / i_steps and begin with a high phase
//            o_step   - registered step output, idle low
//            o_last   - final-cycle indicator
// Revision : 1.0 - initial release
// ============================================================================
module step_pulse_gen #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div_m1,
  input  logic [CNT_W-1:0] i_steps,
  output logic             o_step,
  output logic             o_last
);

  logic             r_active;
  logic             r_step;
  logic [DIV_W-1:0] r_div_m1;
  logic [DIV_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_left;
  logic             w_phase_end;

  assign w_phase_end = (r_cnt == '0);
  assign o_last      = r_active && !r_step && w_phase_end && (r_left == CNT_W'(1));
  assign o_step      = r_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_div_m1 <= '0;
      r_cnt    <= '0;
      r_left   <= '0;
    end else if (i_clear) begin
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_left   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_step   <= 1'b1;
      r_div_m1 <= i_div_m1;
      r_cnt    <= i_div_m1;
      r_left   <= i_steps;
    end else if (r_active) begin
      if (!w_phase_end) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (r_step) begin
        r_step <= 1'b0;
        r_cnt  <= r_div_m1;
      end else if (r_left == CNT_W'(1)) begin
        r_active <= 1'b0;
      end else begin
        r_step <= 1'b1;
        r_cnt  <= r_div_m1;
        r_left <= r_left - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_move_sequencer
// Purpose  : Queues stepper move commands and plays them back-to-back onto a
//            single step/dir pair, pulsing o_move_done after each move.
// Ports    : clk, reset (async, active-high)
//            i_enable, i_abort           - pop gate / kill + flush
//            i_cmd_valid/o_cmd_ready     - command handshake
//            i_cmd_div/steps/dir(/dwell) - command payload
//            o_step_out, o_dir_out       - axis pins
//            o_busy, o_move_done, o_moves_done, o_fifo_level - status
// Config   : STEP_SEQ_DWELL_EN - adds i_cmd_dwell and the post-move DWELL state.
// Revision : 1.0 - initial release
// ============================================================================
module step_move_sequencer
  import step_seq_pkg::*;
#(
  parameter int DIV_W      = C_DIV_W,
  parameter int CNT_W      = C_CNT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int DIR_SETUP  = C_DIR_SETUP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_enable,
  input  logic                          i_abort,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [DIV_W-1:0]              i_cmd_div,
  input  logic [CNT_W-1:0]              i_cmd_steps,
  input  logic                          i_cmd_dir,
`ifdef STEP_SEQ_DWELL_EN
  input  logic [15:0]                   i_cmd_dwell,
`endif
  output logic                          o_step_out,
  output logic                          o_dir_out,
  output logic                          o_busy,
  output logic                          o_move_done,
  output logic [15:0]                   o_moves_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

  // ---------------------------------------------------------------- FIFO
  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  cmd_t             w_wr_cmd;
  cmd_t             w_head;

  // FSM state
  state_t              r_state;
  logic                r_dir_out;
  logic                r_move_done;
  logic [15:0]         r_moves_done;
  logic [SETUP_W-1:0]  r_setup_cnt;
  logic [C_DIV_W-1:0]  r_div_m1;
  logic [C_CNT_W-1:0]  r_steps;
`ifdef STEP_SEQ_DWELL_EN
  logic [15:0]         r_dwell;
  logic [15:0]         r_dwell_cnt;
`endif

  logic                w_start;
  logic                w_last;
  logic                w_dir_change;
  logic [C_DIV_W-1:0]  w_start_div_m1;
  logic [C_CNT_W-1:0]  w_start_steps;

  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign o_cmd_ready = !w_full && !i_abort;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  // The head is consumed on the edge that leaves POP.
  assign w_pop       = (r_state == ST_POP) && !i_abort;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_wr_cmd       = '0;
    w_wr_cmd.div   = C_DIV_W'(i_cmd_div);
    w_wr_cmd.steps = C_CNT_W'(i_cmd_steps);
    w_wr_cmd.dir   = i_cmd_dir;
`ifdef STEP_SEQ_DWELL_EN
    w_wr_cmd.dwell = i_cmd_dwell;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Push and pop in the same cycle leave the level unchanged.
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------- pulse engine
  assign w_dir_change = (w_head.dir != r_dir_out);

  // The pulse engine starts on the edge entering RUN: straight from POP when
  // no direction change is needed, otherwise from the last SETUP cycle.
  assign w_start = !i_abort &&
                   (((r_state == ST_POP) && (w_head.steps != '0) &&
                     (!w_dir_change || (DIR_SETUP == 0))) ||
                    ((r_state == ST_SETUP) && (r_setup_cnt == '0)));

  // In POP the working registers are not yet loaded, so take the head.
  assign w_start_div_m1 = (r_state == ST_POP) ? f_div_m1(w_head.div) : r_div_m1;
  assign w_start_steps  = (r_state == ST_POP) ? w_head.steps : r_steps;

  step_pulse_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) u_pulse (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (i_abort),
    .i_start  (w_start),
    .i_div_m1 (DIV_W'(w_start_div_m1)),
    .i_steps  (CNT_W'(w_start_steps)),
    .o_step   (o_step_out),
    .o_last   (w_last)
  );

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dir_out    <= 1'b0;
      r_move_done  <= 1'b0;
      r_moves_done <= '0;
      r_setup_cnt  <= '0;
      r_div_m1     <= '0;
      r_steps      <= '0;
`ifdef STEP_SEQ_DWELL_EN
      r_dwell      <= '0;
      r_dwell_cnt  <= '0;
`endif
    end else begin
      r_move_done <= 1'b0;
      if (i_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_enable && !w_empty) r_state <= ST_POP;
          end
          ST_POP: begin
            r_div_m1 <= f_div_m1(w_head.div);
            r_steps  <= w_head.steps;
`ifdef STEP_SEQ_DWELL_EN
            r_dwell  <= w_head.dwell;
`endif
            if (w_head.steps == '0) begin
              r_state      <= ST_DONE;
              r_move_done  <= 1'b1;
              r_moves_done <= r_moves_done + 16'd1;
            end else if (w_dir_change) begin
              r_dir_out <= w_head.dir;
              if (DIR_SETUP == 0) begin
                r_state <= ST_RUN;
              end else begin
                r_state     <= ST_SETUP;
                r_setup_cnt <= SETUP_W'(DIR_SETUP - 1);
              end
            end else begin
              r_state <= ST_RUN;
            end
          end
          ST_SETUP: begin
            if (r_setup_cnt == '0) r_state <= ST_RUN;
            else                   r_setup_cnt <= r_setup_cnt - 1'b1;
          end
          ST_RUN: begin
            if (w_last) begin
`ifdef STEP_SEQ_DWELL_EN
              if (r_dwell != '0) begin
                r_state     <= ST_DWELL;
                r_dwell_cnt <= r_dwell - 16'd1;
              end else begin
                r_state      <= ST_DONE;
                r_move_done  <= 1'b1;
                r_moves_done <= r_moves_done + 16'd1;
              end
`else
              r_state      <= ST_DONE;
              r_move_done  <= 1'b1;
              r_moves_done <= r_moves_done + 16'd1;
`endif
            end
          end
`ifdef STEP_SEQ_DWELL_EN
          ST_DWELL: begin
            if (r_dwell_cnt == '0) begin
              r_state      <= ST_DONE;
              r_move_done  <= 1'b1;
              r_moves_done <= r_moves_done + 16'd1;
            end else begin
              r_dwell_cnt <= r_dwell_cnt - 16'd1;
            end
          end
`endif
          ST_DONE: begin
            r_state <= (i_enable && !w_empty) ? ST_POP : ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_dir_out    = r_dir_out;
  assign o_move_done  = r_move_done;
  assign o_moves_done = r_moves_done;
  assign o_fifo_level = r_level;
  assign o_busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_step_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_move_sequencer
// Purpose  : Directed self-checking bench for step_move_sequencer with
//            hand-computed timing. Build with STEP_SEQ_DWELL_EN to also
//            exercise the dwell stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_move_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_div = '0;
  logic [30:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
`ifdef STEP_SEQ_DWELL_EN
  logic [15:0] cmd_dwell = '0;
`endif
  logic        cmd_ready;
  logic        step_out;
  logic        dir_out;
  logic        busy;
  logic        move_done;
  logic [15:0] moves_done;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic        st_h [0:31];
  logic        dr_h [0:31];
  logic        md_h [0:31];
  logic [15:0] mc_h [0:31];

  always #5 clk = ~clk;

  step_move_sequencer #(
    .DIV_W      (32),
    .CNT_W      (31),
    .FIFO_DEPTH (4),
    .DIR_SETUP  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .i_abort      (abort),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_div    (cmd_div),
    .i_cmd_steps  (cmd_steps),
    .i_cmd_dir    (cmd_dir),
`ifdef STEP_SEQ_DWELL_EN
    .i_cmd_dwell  (cmd_dwell),
`endif
    .o_step_out   (step_out),
    .o_dir_out    (dir_out),
    .o_busy       (busy),
    .o_move_done  (move_done),
    .o_moves_done (moves_done),
    .o_fifo_level (fifo_level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] d, input logic [30:0] s, input logic dir);
    cmd_div   = d;
    cmd_steps = s;
    cmd_dir   = dir;
  endtask

  task automatic rec(input int n);
    st_h[n] = step_out;
    dr_h[n] = dir_out;
    md_h[n] = move_done;
    mc_h[n] = moves_done;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] obs;
    logic        seen;
    logic [3:0]  pat;
    int          cnt;
    int          k;
    logic        prev;
    int          got [0:3];

    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_step", step_out, 0);
    check("rst_dir", dir_out, 0);
    check("rst_done", move_done, 0);
    check("rst_count", moves_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);

    // ---------------- 1: div=2 steps=3 dir=0, latency and waveform
    set_cmd(32'd2, 31'd3, 1'b0);
    enable = 1'b1;
    cmd_valid = 1'b1;
    tick;                         // edge k: command written
    cmd_valid = 1'b0;
    check("t1_level_k", fifo_level, 1);
    check("t1_idle_low", step_out, 0);
    tick;                         // POP
    check("t1_pop_low", step_out, 0);
    tick;                         // RUN, first high
    obs  = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs  = {obs[10:0], step_out};
      seen = seen | move_done;
      tick;
    end
    check("t1_wave", obs, 12'hCCC);
    check("t1_no_early_done", seen, 0);
    check("t1_done", move_done, 1);
    check("t1_count", moves_done, 1);
    tick;
    check("t1_done_pulse", move_done, 0);
    check("t1_idle_busy", busy, 0);

    // ---------------- 2: direction change inserts setup
    set_cmd(32'd1, 31'd1, 1'b0);
    cmd_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick;
      rec(n);
      if (n == 0) set_cmd(32'd1, 31'd1, 1'b1);
      if (n == 1) cmd_valid = 1'b0;
    end
    check("t2_a_high", st_h[2], 1);
    check("t2_a_low", st_h[3], 0);
    check("t2_a_done", md_h[4], 1);
    check("t2_dir_pop", dr_h[5], 0);
    check("t2_dir_flip", dr_h[6], 1);
    seen = 1'b0;
    for (int n = 6; n < 14; n++) seen = seen | st_h[n];
    check("t2_setup_low", seen, 0);
    check("t2_b_high", st_h[14], 1);
    check("t2_b_done", md_h[16], 1);
    check("t2_count", mc_h[16], 3);

    // ---------------- 3: fill FIFO with enable low, then drain in order
    enable = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(32'd1, 31'(i + 1), 1'b1);
      check("t3_ready", cmd_ready, (i < 4) ? 1 : 0);
      tick;
    end
    check("t3_level_full", fifo_level, 4);
    check("t3_ready_full", cmd_ready, 0);
    cmd_valid = 1'b0;
    enable = 1'b1;
    cnt  = 0;
    k    = 0;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    for (int n = 0; n < 80; n++) begin
      tick;
      if (step_out && !prev) cnt++;
      prev = step_out;
      if (move_done) begin
        if (k < 4) got[k] = cnt;
        k++;
        cnt = 0;
      end
    end
    check("t3_moves", k, 4);
    for (int i = 0; i < 4; i++) check("t3_order", got[i], i + 1);
    check("t3_count", moves_done, 7);
    check("t3_empty", fifo_level, 0);

    // ---------------- 4: abort mid-RUN with two queued
    set_cmd(32'd10, 31'd100, 1'b1);
    cmd_valid = 1'b1;
    tick;
    set_cmd(32'd3, 31'd3, 1'b1);
    tick;
    set_cmd(32'd4, 31'd4, 1'b0);
    tick;
    cmd_valid = 1'b0;
    repeat (40) tick;
    check("t4_queued", fifo_level, 2);
    check("t4_busy", busy, 1);
    abort = 1'b1;
    cmd_valid = 1'b1;
    set_cmd(32'd1, 31'd1, 1'b0);
    #1;
    check("t4_ready_abort", cmd_ready, 0);
    tick;
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("t4_step_low", step_out, 0);
    check("t4_flushed", fifo_level, 0);
    check("t4_no_done", move_done, 0);
    check("t4_dir_kept", dir_out, 1);
    check("t4_idle", busy, 0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick;
      seen = seen | move_done | step_out;
    end
    check("t4_quiet", seen, 0);
    check("t4_count_held", moves_done, 7);
    check("t4_ready_back", cmd_ready, 1);

    // ---------------- 5: null move, then div=0 steps=2
    set_cmd(32'd5, 31'd0, 1'b0);
    cmd_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick;
      rec(n);
      if (n == 0) set_cmd(32'd0, 31'd2, 1'b1);
      if (n == 1) cmd_valid = 1'b0;
    end
    check("t5_null_done", md_h[2], 1);
    check("t5_null_nostep", st_h[2] | st_h[3], 0);
    check("t5_null_dir", dr_h[2], 1);
    check("t5_null_count", mc_h[2], 8);
    pat = {st_h[4], st_h[5], st_h[6], st_h[7]};
    check("t5_div0_wave", pat, 4'b1010);
    check("t5_div0_done", md_h[8], 1);
    check("t5_count", mc_h[8], 9);

`ifdef STEP_SEQ_DWELL_EN
    // ---------------- 6: dwell of 5, then dwell of 0
    cmd_dwell = 16'd5;
    set_cmd(32'd1, 31'd1, 1'b1);
    cmd_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      tick;
      rec(n);
      if (n == 0) cmd_valid = 1'b0;
    end
    check("t6_high", st_h[2], 1);
    seen = 1'b0;
    for (int n = 3; n < 9; n++) seen = seen | md_h[n] | st_h[n];
    check("t6_dwell_quiet", seen, 0);
    check("t6_dwell_done", md_h[9], 1);
    cmd_dwell = 16'd0;
    cmd_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick;
      rec(n);
      if (n == 0) cmd_valid = 1'b0;
    end
    check("t6_nodwell_done", md_h[4], 1);
    check("t6_nodwell_early", md_h[3], 0);
`endif

    // ---------------- 7: asynchronous reset mid-move
    set_cmd(32'd1, 31'd50, 1'b0);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (5) tick;
    reset = 1'b1;
    #1;
    check("t7_step", step_out, 0);
    check("t7_dir", dir_out, 0);
    check("t7_count", moves_done, 0);
    check("t7_level", fifo_level, 0);
    check("t7_busy", busy, 0);
    tick;
    reset = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
